edge_bit_counter: RTL and testbench

EDGE_BIT_COUNTER -- requirements
Module: edge_bit_counter

---
 rtl/edge_bit_counter_pkg.sv | 8 +
 rtl/edge_bit_counter.sv | 45 ++++
 tb/tb_edge_bit_counter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/edge_bit_counter_pkg.sv
// Shared UART receive-path definitions: default counter widths used across the RX blocks.
`timescale 1ns/1ps
package edge_bit_counter_pkg;

  localparam int unsigned UART_PRESCALE_W = 5;
  localparam int unsigned UART_BIT_CNT_W  = 4;

endpackage

// File: rtl/edge_bit_counter.sv
// UART RX oversampling counter: edge index within a bit and bit index within a frame.
`timescale 1ns/1ps
module edge_bit_counter
  import edge_bit_counter_pkg::*;
#(
  parameter int unsigned PRESCALE_W = UART_PRESCALE_W,
  parameter int unsigned BIT_CNT_W  = UART_BIT_CNT_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt
);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [PRESCALE_W-1:0] w_terminal;
  logic                  w_last_edge;

  // Modulo subtraction: Prescale=0 gives all-ones, so a bit then spans 2^PRESCALE_W edges.
  assign w_terminal  = Prescale - PRESCALE_W'(1);
  // >= rather than == so a mid-bit Prescale reduction wraps instead of running past T.
  assign w_last_edge = (r_edge_cnt >= w_terminal);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (!enable) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_last_edge) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
    end
  end

  assign edge_cnt = r_edge_cnt;
  assign bit_cnt  = r_bit_cnt;

endmodule

// File: tb/tb_edge_bit_counter.sv
// Directed self-checking bench for edge_bit_counter.
`timescale 1ns/1ps
module tb_edge_bit_counter;

  logic       CLK;
  logic       RST;
  logic       enable;
  logic [4:0] Prescale;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;

  int unsigned n_cmp;
  int unsigned n_err;

  edge_bit_counter #(
    .PRESCALE_W(5),
    .BIT_CNT_W (4)
  ) u_dut (
    .CLK     (CLK),
    .RST     (RST),
    .enable  (enable),
    .Prescale(Prescale),
    .edge_cnt(edge_cnt),
    .bit_cnt (bit_cnt)
  );

  initial CLK = 1'b0;
  always #2.5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_both(input string tag, input int exp_edge, input int exp_bit);
    chk({tag, ".edge"}, int'(edge_cnt), exp_edge);
    chk({tag, ".bit"},  int'(bit_cnt),  exp_bit);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_cycle();
    enable = 1'b0;
    tick();
    chk_both("clear", 0, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    RST      = 1'b0;
    enable   = 1'b0;
    Prescale = 5'd8;

    #1;
    chk_both("reset_t0", 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_both("reset_hold", 0, 0);
    end
    RST = 1'b1;
    tick();
    chk_both("post_reset_idle", 0, 0);

    // Prescale=8 for 30 cycles: edge = k%8, bit = k/8
    enable = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk_both("ps8_run", k % 8, k / 8);
    end

    // Drop enable at edge=5, bit=2
    clear_cycle();
    enable = 1'b1;
    for (int k = 1; k <= 21; k++) tick();
    chk_both("ps8_pre_drop", 5, 2);
    clear_cycle();
    enable = 1'b1;
    tick();
    chk_both("restart_first", 1, 0);

    // Prescale 8 -> 4 while edge=6: wrap immediately
    for (int k = 0; k < 5; k++) tick();
    chk_both("ps8_edge6", 6, 0);
    Prescale = 5'd4;
    tick();
    chk_both("ps_change_wrap", 0, 1);
    tick();
    chk_both("ps4_continue", 1, 1);

    // Prescale=16 for 256 cycles: bit_cnt wraps 15 -> 0
    clear_cycle();
    Prescale = 5'd16;
    enable   = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      tick();
      chk_both("ps16_run", k % 16, (k / 16) % 16);
    end

    // Prescale=1: edge stuck at 0, bit advances every cycle
    clear_cycle();
    Prescale = 5'd1;
    enable   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_both("ps1_run", 0, k % 16);
    end

    // Prescale=0: terminal is 31, a bit spans 32 cycles
    clear_cycle();
    Prescale = 5'd0;
    enable   = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      tick();
      chk_both("ps0_run", k % 32, k / 32);
    end

    // Asynchronous reset mid-count, between edges, with enable held high
    clear_cycle();
    Prescale = 5'd8;
    enable   = 1'b1;
    for (int k = 0; k < 11; k++) tick();
    chk_both("pre_async", 3, 1);
    #1;
    RST = 1'b0;
    #0.5;
    chk_both("async_reset", 0, 0);
    tick();
    chk_both("reset_over_enable", 0, 0);
    #1;
    RST = 1'b1;
    tick();
    chk_both("post_async_first", 1, 0);
    tick();
    chk_both("post_async_second", 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
